// File: rtl/posit_pkg.sv
// Shared types and helpers for the posit result path.
// Latency: none (package only).
// Backpressure: none (package only).
package posit_pkg;

    // Posit width the result entry is built for; matches the adder's N.
    localparam int POSIT_N = 8;

    // One buffered adder result: special-case flags plus the posit word.
    typedef struct packed {
        logic               inf;
        logic               zero;
        logic [POSIT_N-1:0] result;
    } posit_res_t;

    localparam int POSIT_RES_W = $bits(posit_res_t);

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/posit_sync_fifo.sv
// Synchronous FIFO holding adder results, with occupancy count.
// Latency: a push is visible at rd_dat on the cycle after the write edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module posit_sync_fifo
    import posit_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                wr_dat,
    output logic [W-1:0]                rd_dat,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
    output logic                        full
);

    localparam int AW = clog2(DEPTH);
    localparam int OW = clog2(DEPTH + 1);
    localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (occupancy == '0);
    assign full    = (occupancy == DEPTH_C);
    assign pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = push & (~full | pop_ok);

    // Head word is forced to zero while empty so stale storage never leaks out.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/posit_result_buffer.sv
// Credit-managed in-order result buffer behind the posit adder. Optional stats via POSIT_RESBUF_STATS_EN.
// Latency: add_done to m_valid/m_result is 1 cycle; issue_ok is decoded from registers only.
// Backpressure: m_ready stalls the head; issue_ok withdraws credit once stored + in-flight reaches DEPTH.
module posit_result_buffer
    import posit_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        issue_start,
    output logic                        issue_ok,
    input  logic                        add_done,
    input  logic                        add_inf,
    input  logic                        add_zero,
    input  logic [N-1:0]                add_result,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [N-1:0]                m_result,
    output logic                        m_inf,
    output logic                        m_zero,
    output logic [clog2(DEPTH+1)-1:0]   occupancy,
`ifdef POSIT_RESBUF_STATS_EN
    output logic [15:0]                 stat_inf_cnt,
    output logic [15:0]                 stat_zero_cnt,
`endif
    output logic                        overflow
);

    localparam int OW = clog2(DEPTH + 1);
    localparam logic [OW:0] DEPTH_W = (OW + 1)'(DEPTH);

    logic [OW-1:0] inflight;
    logic [OW:0]   credit_used;
    logic          full;
    logic          pop;
    logic          wr_acc;
    posit_res_t    wr_ent;
    posit_res_t    rd_ent;

    assign wr_ent = '{inf: add_inf, zero: add_zero, result: add_result};

    posit_sync_fifo #(
        .W     (POSIT_RES_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (add_done),
        .pop       (pop),
        .wr_dat    (wr_ent),
        .rd_dat    (rd_ent),
        .occupancy (occupancy),
        .full      (full)
    );

    assign m_valid  = (occupancy != '0);
    assign pop      = m_valid & m_ready;
    assign m_result = rd_ent.result;
    assign m_inf    = rd_ent.inf;
    assign m_zero   = rd_ent.zero;
    assign wr_acc   = add_done & (~full | pop);

    // Credit: everything stored plus everything the adder still owes us.
    assign credit_used = {1'b0, occupancy} + {1'b0, inflight};
    assign issue_ok    = (credit_used < DEPTH_W);

    // Track issued-but-not-completed operations; never underflow, saturate at the top.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            inflight <= '0;
        end else if (issue_start && !add_done) begin
            if (inflight != '1) begin
                inflight <= inflight + 1'b1;
            end
        end else if (add_done && !issue_start) begin
            if (inflight != '0) begin
                inflight <= inflight - 1'b1;
            end
        end
    end

    // Sticky protocol-error flag: dropped result or issue without credit.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            overflow <= 1'b0;
        end else if ((add_done && full && !pop) || (issue_start && !issue_ok)) begin
            overflow <= 1'b1;
        end
    end

`ifdef POSIT_RESBUF_STATS_EN
    // Saturating counts of accepted inf / zero results.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_inf_cnt  <= '0;
            stat_zero_cnt <= '0;
        end else begin
            if (wr_acc && add_inf && stat_inf_cnt != 16'hFFFF) begin
                stat_inf_cnt <= stat_inf_cnt + 16'd1;
            end
            if (wr_acc && add_zero && stat_zero_cnt != 16'hFFFF) begin
                stat_zero_cnt <= stat_zero_cnt + 16'd1;
            end
        end
    end
`else
    logic unused_wr_acc;
    assign unused_wr_acc = wr_acc;
`endif

endmodule

// File: tb/tb_posit_result_buffer.sv
// Bench for posit_result_buffer (N=8, DEPTH=4): vector table, directed corners, random vs queue model.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: m_ready driven from tables and $urandom.
module tb_posit_result_buffer;

    localparam int N     = 8;
    localparam int DEPTH = 4;
    localparam int OW    = 3;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          issue_start;
    logic          issue_ok;
    logic          add_done;
    logic          add_inf;
    logic          add_zero;
    logic [N-1:0]  add_result;
    logic          m_valid;
    logic          m_ready;
    logic [N-1:0]  m_result;
    logic          m_inf;
    logic          m_zero;
    logic [OW-1:0] occupancy;
    logic          overflow;
`ifdef POSIT_RESBUF_STATS_EN
    logic [15:0]   stat_inf_cnt;
    logic [15:0]   stat_zero_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    posit_result_buffer #(.N(N), .DEPTH(DEPTH)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .issue_start (issue_start),
        .issue_ok    (issue_ok),
        .add_done    (add_done),
        .add_inf     (add_inf),
        .add_zero    (add_zero),
        .add_result  (add_result),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_result    (m_result),
        .m_inf       (m_inf),
        .m_zero      (m_zero),
        .occupancy   (occupancy),
`ifdef POSIT_RESBUF_STATS_EN
        .stat_inf_cnt  (stat_inf_cnt),
        .stat_zero_cnt (stat_zero_cnt),
`endif
        .overflow    (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic st, input logic dn, input logic [7:0] r,
                         input logic i, input logic z, input logic rdy);
        issue_start = st;
        add_done    = dn;
        add_result  = r;
        add_inf     = i;
        add_zero    = z;
        m_ready     = rdy;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] r,
                             input logic i, input logic z, input logic [2:0] o,
                             input logic ok, input logic ov);
        chk({tag, ".m_valid"},   32'(m_valid),   32'(v));
        chk({tag, ".m_result"},  32'(m_result),  32'(r));
        chk({tag, ".m_inf"},     32'(m_inf),     32'(i));
        chk({tag, ".m_zero"},    32'(m_zero),    32'(z));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(o));
        chk({tag, ".issue_ok"},  32'(issue_ok),  32'(ok));
        chk({tag, ".overflow"},  32'(overflow),  32'(ov));
    endtask

    // Reset with all inputs active; they must be ignored.
    task automatic do_reset();
        aresetn = 1'b0;
        drive(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        aresetn = 1'b1;
        idle();
        check_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    typedef struct {
        logic       st, dn;
        logic [7:0] r;
        logic       i, z, rdy;
        logic       ev;
        logic [7:0] er;
        logic       ei, ez;
        logic [2:0] eo;
        logic       eok;
    } vec_t;

    vec_t tbl[15];

    // Reference model state for the random phase.
    logic [9:0] mq[$];
    int         m_infl;
    logic       m_ovf;

    initial begin
        logic [9:0] head;
        logic       st, dn, rdy, i, z, popm, fullm;
        logic [7:0] r;

        aresetn = 1'b0;
        idle();

        // {st,dn,r,i,z,rdy, ev,er,ei,ez,eo,eok}; overflow expected 0 throughout
        tbl[0]  = '{1,0,8'h00,0,0,0, 0,8'h00,0,0,3'd0,1};
        tbl[1]  = '{0,1,8'h40,0,0,0, 1,8'h40,0,0,3'd1,1};
        tbl[2]  = '{0,0,8'h00,0,0,1, 0,8'h00,0,0,3'd0,1};
        tbl[3]  = '{1,0,8'h00,0,0,0, 0,8'h00,0,0,3'd0,1};
        tbl[4]  = '{1,0,8'h00,0,0,0, 0,8'h00,0,0,3'd0,1};
        tbl[5]  = '{1,0,8'h00,0,0,0, 0,8'h00,0,0,3'd0,1};
        tbl[6]  = '{1,0,8'h00,0,0,0, 0,8'h00,0,0,3'd0,0};
        tbl[7]  = '{0,1,8'h11,0,0,0, 1,8'h11,0,0,3'd1,0};
        tbl[8]  = '{0,0,8'h00,0,0,1, 0,8'h00,0,0,3'd0,1};
        tbl[9]  = '{0,1,8'h12,0,0,0, 1,8'h12,0,0,3'd1,1};
        tbl[10] = '{0,1,8'h80,1,0,0, 1,8'h12,0,0,3'd2,1};
        tbl[11] = '{0,1,8'h00,0,1,0, 1,8'h12,0,0,3'd3,1};
        tbl[12] = '{0,0,8'h00,0,0,1, 1,8'h80,1,0,3'd2,1};
        tbl[13] = '{0,0,8'h00,0,0,1, 1,8'h00,0,1,3'd1,1};
        tbl[14] = '{0,0,8'h00,0,0,1, 0,8'h00,0,0,3'd0,1};

        // Reset release and input masking during reset.
        do_reset();

        // Latency, credit and flag vectors.
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].st, tbl[k].dn, tbl[k].r, tbl[k].i, tbl[k].z, tbl[k].rdy);
            tick();
            check_out($sformatf("vec%0d", k), tbl[k].ev, tbl[k].er, tbl[k].ei,
                      tbl[k].ez, tbl[k].eo, tbl[k].eok, 1'b0);
        end
        idle();

        // Full buffer with simultaneous pop and push.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, 8'(k * 16), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        check_out("full", 1'b1, 8'h10, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h50, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("fullpop", 1'b1, 8'h20, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0);
        for (int k = 3; k <= 5; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            tick();
            check_out($sformatf("order%0d", k), 1'b1, 8'(k * 16), 1'b0, 1'b0,
                      3'(6 - k), 1'b1, 1'b0);
        end
        tick();
        check_out("order_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);

        // Overflow on write while full and stalled; the dropped value never shows.
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, 8'(k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0);
        tick();
        check_out("ovf_set", 1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
        idle();
        tick();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            tick();
            check_out($sformatf("ovf_drain%0d", k), 1'b1, 8'(k), 1'b0, 1'b0,
                      3'(5 - k), 1'b1, 1'b1);
        end
        tick();
        check_out("ovf_empty", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
        idle();

        // Overflow on issue without credit; issue still counted.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_out("credit_out", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        idle();
        check_out("issue_ovf", 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        // Five in flight: four completions leave one owed, so full and no credit.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        check_out("issue_ovf_cnt", 1'b1, 8'hA0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check_out("issue_ovf_owed", 1'b1, 8'hA1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1);
        idle();

        // Reset mid-operation: late completions become plain writes.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            tick();
        end
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 8'(8'h66 + k), 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        check_out("late_done", 1'b1, 8'h66, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick();
        idle();

        // Random legal traffic against a queue model.
        do_reset();
        mq.delete();
        m_infl = 0;
        m_ovf  = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            st  = ((mq.size() + m_infl) < DEPTH) && ($urandom_range(0, 2) == 0);
            dn  = (m_infl > 0) && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 3) != 0);
            r   = 8'($urandom);
            i   = 1'($urandom);
            z   = 1'($urandom);
            drive(st, dn, r, i, z, rdy);
            if (st && (mq.size() + m_infl) >= DEPTH) m_ovf = 1'b1;
            fullm = (mq.size() == DEPTH);
            popm  = (mq.size() != 0) && rdy;
            if (popm) void'(mq.pop_front());
            if (dn) begin
                if (!fullm || popm) mq.push_back({i, z, r});
                else m_ovf = 1'b1;
            end
            if (st && !dn) m_infl++;
            else if (dn && !st && m_infl > 0) m_infl--;
            tick();
            head = (mq.size() != 0) ? mq[0] : 10'd0;
            check_out("rand", 1'(mq.size() != 0), head[7:0], head[9], head[8],
                      3'(mq.size()), 1'((mq.size() + m_infl) < DEPTH), m_ovf);
        end
        idle();

`ifdef POSIT_RESBUF_STATS_EN
        // Saturating stats counters and their reset.
        do_reset();
        chk("stat_inf_rst", 32'(stat_inf_cnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("stat_inf", 32'(stat_inf_cnt), 32'd3);
        chk("stat_zero", 32'(stat_zero_cnt), 32'd2);
        do_reset();
        chk("stat_inf_clr", 32'(stat_inf_cnt), 32'd0);
        chk("stat_zero_clr", 32'(stat_zero_cnt), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
